// File: rtl/seg7_pkg.sv
// Shared types and glyph helpers for the register-1 seven-segment display stage.
// Glyphs are {g,f,e,d,c,b,a}, active-low, for a common-anode display.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [6:0] GLYPH_BLANK = 7'h7F;
  localparam logic [3:0] BCD_SHIFTS  = 4'd8;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_reg_display_bin2bcd.sv
// Sequential shift-add-3 (double dabble) converter: 8-bit binary to three BCD nibbles.
// start loads the operand; done is high during the cycle that performs the last shift.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] value,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  // {hundreds, tens, ones, binary}
  logic [19:0] sr_reg;
  logic [3:0]  cnt_reg;
  logic [11:0] adj;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (sr_reg[8 + gi*4 +: 4] >= 4'd5) ?
                              sr_reg[8 + gi*4 +: 4] + 4'd3 :
                              sr_reg[8 + gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_reg  <= '0;
      cnt_reg <= '0;
    end else if (start) begin
      sr_reg  <= {12'd0, value};
      cnt_reg <= BCD_SHIFTS;
    end else if (cnt_reg != 4'd0) begin
      sr_reg  <= {adj[10:0], sr_reg[7:0], 1'b0};
      cnt_reg <= cnt_reg - 4'd1;
    end
  end

  assign done     = (cnt_reg == 4'd1);
  assign hundreds = sr_reg[19:16];
  assign tens     = sr_reg[15:12];
  assign ones     = sr_reg[11:8];

endmodule

// File: rtl/seg7_reg_display.sv
// Shows the CPU register-1 low byte on a 4-digit multiplexed seven-segment display,
// as decimal with leading-zero blanking or as two hex digits.
module seg7_reg_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value,
  input  logic       hex_mode,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       busy
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  state_t state_reg, state_next;

  logic       cap_valid_reg;
  logic       cap_hex_reg;
  logic [7:0] cap_value_reg;
  logic       capture;
  logic       start;

  logic       bcd_done;
  logic [3:0] bcd_h, bcd_t, bcd_o;

  logic [6:0] commit_glyph [4];
  logic [6:0] digit_reg    [4];

  logic [CW-1:0] refresh_cnt_reg;
  logic [1:0]    idx_reg;
  logic [6:0]    seg_reg;
  logic [3:0]    an_reg;

  // The valid flag clear makes the captured pair unmatchable after reset.
  assign capture = (state_reg == ST_IDLE) &&
                   (!cap_valid_reg || (cap_hex_reg != hex_mode) || (cap_value_reg != value));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (capture) state_next = hex_mode ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (bcd_done) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_reg != ST_IDLE);
    start = capture && !hex_mode;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid_reg <= 1'b0;
      cap_hex_reg   <= 1'b0;
      cap_value_reg <= '0;
    end else if (capture) begin
      cap_valid_reg <= 1'b1;
      cap_hex_reg   <= hex_mode;
      cap_value_reg <= value;
    end
  end

  bin2bcd_seq u_bcd (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .value    (value),
    .done     (bcd_done),
    .hundreds (bcd_h),
    .tens     (bcd_t),
    .ones     (bcd_o)
  );

  always_comb begin
    commit_glyph[3] = GLYPH_BLANK;
    commit_glyph[2] = GLYPH_BLANK;
    commit_glyph[1] = GLYPH_BLANK;
    commit_glyph[0] = GLYPH_BLANK;
    if (cap_hex_reg) begin
      commit_glyph[1] = hex_glyph(cap_value_reg[7:4]);
      commit_glyph[0] = hex_glyph(cap_value_reg[3:0]);
    end else begin
      if (bcd_h != 4'd0)                       commit_glyph[2] = hex_glyph(bcd_h);
      if ((bcd_h != 4'd0) || (bcd_t != 4'd0))  commit_glyph[1] = hex_glyph(bcd_t);
      commit_glyph[0] = hex_glyph(bcd_o);
    end
  end

  // All four digits update on the same edge so the scan never shows a mix.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      always_ff @(posedge clk) begin
        if (rst)                        digit_reg[gi] <= GLYPH_BLANK;
        else if (state_reg == ST_DONE)  digit_reg[gi] <= commit_glyph[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt_reg <= '0;
      idx_reg         <= '0;
      seg_reg         <= GLYPH_BLANK;
      an_reg          <= 4'hF;
    end else begin
      seg_reg <= digit_reg[idx_reg];
      an_reg  <= ~(4'b0001 << idx_reg);
      if (refresh_cnt_reg == LAST) begin
        refresh_cnt_reg <= '0;
        idx_reg         <= idx_reg + 2'd1;
      end else begin
        refresh_cnt_reg <= refresh_cnt_reg + CW'(1);
      end
    end
  end

  assign seg = seg_reg;
  assign an  = an_reg;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_seg7_reg_display.sv
// Randomised bench for seg7_reg_display: a cycle-level behavioural model predicts
// seg/an/dp/busy every cycle; literal checks pin the model on known values.
module tb_seg7_reg_display;

  localparam int DIV = 4;
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] GL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] value = 8'd0;
  logic       hex_mode = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_reg_display #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .hex_mode (hex_mode),
    .seg      (seg),
    .an       (an),
    .dp       (dp),
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] m_disp [4];
  logic [6:0] m_pend [4];
  logic [6:0] m_seg;
  logic [3:0] m_an;
  bit         m_busy;
  int         m_left;
  bit         m_cap_valid;
  logic       m_cap_hex;
  logic [7:0] m_cap_val;
  int         m_cyc;
  bit         m_valid = 0;

  function automatic logic [6:0] glyph(input int d);
    logic [3:0] n;
    n = d[3:0];
    return GL[n];
  endfunction

  task automatic compute_pending(input logic hx, input logic [7:0] v);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    m_pend[3] = BLANK;
    if (hx) begin
      m_pend[2] = BLANK;
      m_pend[1] = glyph(v / 16);
      m_pend[0] = glyph(v % 16);
    end else begin
      m_pend[2] = (h != 0) ? glyph(h) : BLANK;
      m_pend[1] = (h != 0 || t != 0) ? glyph(t) : BLANK;
      m_pend[0] = glyph(o);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1;
      m_seg = BLANK; m_an = 4'hF; m_busy = 0; m_left = 0;
      m_cap_valid = 0; m_cap_hex = 0; m_cap_val = 0; m_cyc = 0;
      for (int i = 0; i < 4; i++) m_disp[i] = BLANK;
    end else if (m_valid) begin
      int idx;
      idx   = (m_cyc / DIV) % 4;
      m_seg = m_disp[idx];
      m_an  = ~(4'b0001 << idx);
      m_cyc = (m_cyc + 1) % (4 * DIV);
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) for (int i = 0; i < 4; i++) m_disp[i] = m_pend[i];
      end else if (!m_cap_valid || m_cap_hex !== hex_mode || m_cap_val !== value) begin
        m_cap_valid = 1; m_cap_hex = hex_mode; m_cap_val = value;
        compute_pending(hex_mode, value);
        m_left = hex_mode ? 1 : 9;
      end
      m_busy = (m_left > 0);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_seg",  {25'd0, seg}, {25'd0, m_seg});
      chk("model_an",   {28'd0, an},  {28'd0, m_an});
      chk("model_busy", {31'd0, busy}, {31'd0, m_busy});
      chk("model_dp",   {31'd0, dp},  32'd1);
    end
  end

  // ---------------- directed literal checks ----------------
  task automatic check_digit(input int pos, input logic [6:0] exp, input string name);
    logic [3:0] target;
    bit found;
    target = ~(4'b0001 << pos);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an == target) found = 1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL %s: digit %0d never lit (an=%b)", name, pos, an);
    end else begin
      chk(name, {25'd0, seg}, {25'd0, exp});
    end
  endtask

  task automatic count_busy(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (busy) n++;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    bit found;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("first_an",  {28'd0, an},  32'hE);
    chk("first_seg", {25'd0, seg}, 32'h7F);

    wait_cycles(14);
    check_digit(0, 7'b1000000, "zero_d0");
    check_digit(1, BLANK, "zero_d1");
    check_digit(2, BLANK, "zero_d2");

    value = 8'd255;
    count_busy(30, n);
    chk("busy_dec_255", n, 32'd9);
    check_digit(3, BLANK,      "d255_d3");
    check_digit(2, 7'b0100100, "d255_d2");
    check_digit(1, 7'b0010010, "d255_d1");
    check_digit(0, 7'b0010010, "d255_d0");

    value = 8'd7;
    wait_cycles(14);
    check_digit(0, 7'b1111000, "d7_d0");
    check_digit(1, BLANK,      "d7_d1");
    check_digit(2, BLANK,      "d7_d2");
    check_digit(3, BLANK,      "d7_d3");

    value = 8'd105;
    wait_cycles(14);
    check_digit(2, 7'b1111001, "d105_d2");
    check_digit(1, 7'b1000000, "d105_d1");
    check_digit(0, 7'b0010010, "d105_d0");

    hex_mode = 1'b1;
    value = 8'hAF;
    count_busy(10, n);
    chk("busy_hex", n, 32'd1);
    check_digit(1, 7'b0001000, "hAF_d1");
    check_digit(0, 7'b0001110, "hAF_d0");
    check_digit(2, BLANK,      "hAF_d2");
    check_digit(3, BLANK,      "hAF_d3");

    hex_mode = 1'b0;
    value = 8'd200;
    wait_cycles(3);
    value = 8'd13;
    wait_cycles(30);
    check_digit(0, 7'b0110000, "d13_d0");
    check_digit(1, 7'b1111001, "d13_d1");
    check_digit(2, BLANK,      "d13_d2");

    // scan order from the start of a digit-0 slot
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an == 4'b0111) found = 1;
    end
    for (int i = 0; i < 10 && found && an != 4'b1110; i++) @(negedge clk);
    if (!found || an != 4'b1110) begin
      checks++; errors++;
      $display("FAIL scan_sync: an=%b never reached scan start", an);
    end else begin
      for (int i = 0; i <= 16; i++) begin
        logic [3:0] e;
        e = ~(4'b0001 << ((i / 4) % 4));
        chk("scan_order", {28'd0, an}, {28'd0, e});
        @(negedge clk);
      end
    end

    wait_cycles(2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_seg",  {25'd0, seg},  32'h7F);
    chk("rst_an",   {28'd0, an},   32'hF);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    for (int it = 0; it < 80; it++) begin
      value    = 8'($urandom);
      hex_mode = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      wait_cycles($urandom_range(1, 25));
    end
    wait_cycles(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_reg_display.md
# seg7_reg_display

Display stage driven by the CPU's register-1 low byte. It converts the 8-bit value to decimal BCD with a sequential shift-add-3 converter, or passes it through as hex. It then time-multiplexes the result onto a 4-digit common-anode seven-segment display. It sits directly downstream of the top level's `reg_1_eight_bits` output and replaces raw LED drive.

## Interface
- `REFRESH_DIV`, default 100000: clk cycles each digit is lit; minimum 2.
- `clk  in  1`: system clock.
- `rst  in  1`: reset; synchronous, active-high.
- `value  in  8`: binary value to display; sampled only in IDLE.
- `hex_mode  in  1`: 1 shows hex, 0 shows decimal; sampled with `value`.
- `seg  out  7`: segments {g,f,e,d,c,b,a}, active-low.
- `an  out  4`: digit enables, active-low; `an[0]` is the rightmost digit.
- `dp  out  1`: decimal point, active-low; constantly 1.
- `busy  out  1`: conversion in progress.

## Operation
- Converter FSM has three states: IDLE, SHIFT, DONE.
- **IDLE:** if `{hex_mode,value}` differs from the captured pair, capture both.
  - Decimal capture: clear the 12-bit BCD accumulator, load a 4-bit shift counter, go to SHIFT.
  - Hex capture: go to DONE.
- **SHIFT:** each cycle, add 3 to every BCD nibble ≥ 5, then shift the {BCD, binary} register left 1. After 8 shifts go to DONE.
- **DONE:** commit all four digit registers in one cycle (no tearing), then return to IDLE.
  - Decimal: digit3 blank; digit2 = hundreds, blanked if 0; digit1 = tens, blanked if hundreds and tens are both 0; digit0 always shown.
  - Hex: digit3 and digit2 blank; digit1 = `value[7:4]`, digit0 = `value[3:0]`.
- `value` changes during SHIFT/DONE are ignored. They are picked up at the next IDLE cycle by the compare; no update is lost if the input is stable ≥ 1 cycle in IDLE.
- The captured pair resets to an impossible marker (flag bit clear), so the first IDLE cycle after reset always captures.
- Refresh scan:
  - A counter runs 0..`REFRESH_DIV`-1. On wrap, the digit index advances 0→1→2→3→0.
  - `an` = one-hot-low of the index; `seg` = glyph of that digit.
  - Blank glyph = 7'h7F. Glyphs 0–F use the standard encoding (0 = 7'b1000000, 1 = 7'b1111001, A = 7'b0001000, F = 7'b0001110).

## Timing
- Reset values: `seg`=7'h7F, `an`=4'hF, `dp`=1, `busy`=0, FSM=IDLE, all digits blank, refresh counter 0, digit index 0.
- `seg`/`an` are registered from the index and digit registers, 1-cycle delay. The first cycle after reset release shows `an`=4'b1110 with a blank glyph.
- Decimal latency, with the capture edge as E0:
  - shifts occur at E1..E8;
  - commit occurs at E9;
  - `busy` is 1 from after E0 through E9 (9 cycles);
  - the new glyph appears on `seg` at E10 if its digit is lit.
- Hex latency: commit at E1; `busy` is high for 1 cycle.
- Simultaneous commit and refresh wrap: the wrap uses the old index. The newly committed digit is visible on the next cycle.
- Reset mid-conversion: aborts immediately. All state returns to reset values and the display is blank until a fresh conversion.

## Structure
- Shared package `seg7_pkg`: FSM state enum, glyph constants (`GLYPH_BLANK`, a 16-entry hex glyph table as a function).
- Sub-module `bin2bcd_seq`: the shift-add-3 datapath and shift counter.
  - Handshake: start/value in, done pulse plus three BCD nibbles out.
  - The FSM wrapper, digit registers, blanking and scan logic live in the top.

## Test plan
All scenarios use `REFRESH_DIV`=4.
- **Reset:** assert `rst` mid-scan → next cycle `seg`=7'h7F, `an`=4'hF, `busy`=0.
- **Decimal, value=255:** `busy` high for exactly 9 cycles. Scan shows digit2/1/0 = 2,5,5 (7'b0100100, 7'b0010010, 7'b0010010) and digit3 blank.
- **Leading-zero blanking:** value=7 shows digit0=7'b1111000 with digits 1–3 blank; value=0 shows digit0=7'b1000000 only; value=105 shows 1,0,5 (inner zero kept).
- **Hex, value=8'hAF:** `busy` high for 1 cycle; digit1=7'b0001000, digit0=7'b0001110; digits 2 and 3 blank.
- **Change mid-conversion:** value 200→13 at E3. Display commits 200 at E9, then recaptures and commits 13 nine cycles later. No intermediate glyphs appear.
- **Scan order:** with a stable display, `an` cycles 1110→1101→1011→0111, each held 4 cycles, and wraps to 1110.
